// File: rtl/xor_cipher_ctrl.sv
`timescale 1ns/1ps
// Sequencer for the XOR encryption engine: serial key/message loader, engine
// handshake with per-phase timeout, and MSB-first valid/ready ciphertext streamer.
module xor_cipher_ctrl #(
    parameter int MSG_SIZE    = 64,
    parameter int KEY_SIZE    = 8,
    parameter int ENC_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        iBit,
    input  logic                        iBit_valid,
    input  logic                        iBit_sel,
    output logic [MSG_SIZE-1:0]         oMessage,
    output logic [KEY_SIZE-1:0]         oKey,
    output logic [$clog2(MSG_SIZE):0]   oMessage_bit_counter,
    output logic [$clog2(KEY_SIZE):0]   oKey_bit_counter,
    output logic                        oEngine_ena,
    output logic                        oEngine_rst_n,
    input  logic                        iEncryption_status,
    input  logic [MSG_SIZE-1:0]         iCiphertext,
    output logic                        oSerial_out,
    output logic                        oSerial_valid,
    input  logic                        iSerial_ready,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oError
);
    localparam int MCW = $clog2(MSG_SIZE) + 1;
    localparam int KCW = $clog2(KEY_SIZE) + 1;
    localparam int TCW = $clog2(ENC_TIMEOUT) + 1;

    localparam logic [MCW-1:0] MSG_FULL = MCW'(MSG_SIZE);
    localparam logic [MCW-1:0] MSG_LAST = MCW'(MSG_SIZE - 1);
    localparam logic [KCW-1:0] KEY_FULL = KCW'(KEY_SIZE);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(ENC_TIMEOUT - 1);

    localparam logic [2:0] S_LOAD     = 3'd0;
    localparam logic [2:0] S_ENC_RISE = 3'd1;
    localparam logic [2:0] S_ENC_FALL = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;

    logic [2:0]          r_state;
    logic [MSG_SIZE-1:0] r_msg;
    logic [KEY_SIZE-1:0] r_key;
    logic [MCW-1:0]      r_msg_cnt;
    logic [KCW-1:0]      r_key_cnt;
    logic [MSG_SIZE-1:0] r_shreg;
    logic [MCW-1:0]      r_sent_cnt;
    logic [TCW-1:0]      r_tmo;
    logic                r_eng_ena;
    logic                r_eng_rst_n;
    logic                r_valid;
    logic                r_done;
    logic                r_error;

    logic [2:0] w_state_next;
    logic       w_msg_full;
    logic       w_key_full;
    logic       w_msg_take;
    logic       w_key_take;
    logic       w_in_enc;
    logic       w_tmo_hit;
    logic       w_accept;
    logic       w_last;

    assign w_msg_full = (r_msg_cnt == MSG_FULL);
    assign w_key_full = (r_key_cnt == KEY_FULL);
    assign w_msg_take = (r_state == S_LOAD) && iBit_valid &&  iBit_sel && !w_msg_full;
    assign w_key_take = (r_state == S_LOAD) && iBit_valid && !iBit_sel && !w_key_full;
    assign w_in_enc   = (r_state == S_ENC_RISE) || (r_state == S_ENC_FALL);
    assign w_tmo_hit  = (r_tmo == TMO_LAST);
    assign w_accept   = (r_state == S_SEND) && r_valid && iSerial_ready;
    assign w_last     = w_accept && (r_sent_cnt == MSG_LAST);

    // A status edge seen on the same cycle as the timeout wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:     if (w_msg_full && w_key_full) w_state_next = S_ENC_RISE;
            S_ENC_RISE: if (iEncryption_status)       w_state_next = S_ENC_FALL;
                        else if (w_tmo_hit)           w_state_next = S_CLEAR;
            S_ENC_FALL: if (!iEncryption_status)      w_state_next = S_SEND;
                        else if (w_tmo_hit)           w_state_next = S_CLEAR;
            S_SEND:     if (w_last)                   w_state_next = S_CLEAR;
            S_CLEAR:                                  w_state_next = S_LOAD;
            default:                                  w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_msg       <= '0;
            r_key       <= '0;
            r_msg_cnt   <= '0;
            r_key_cnt   <= '0;
            r_shreg     <= '0;
            r_sent_cnt  <= '0;
            r_tmo       <= '0;
            r_eng_ena   <= 1'b0;
            r_eng_rst_n <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else if (ena) begin
            r_state     <= w_state_next;
            r_eng_ena   <= (w_state_next == S_ENC_RISE) || (w_state_next == S_ENC_FALL);
            r_eng_rst_n <= (w_state_next != S_CLEAR);
            r_valid     <= (w_state_next == S_SEND);
            r_done      <= w_last;

            if (w_msg_take) begin
                r_msg     <= {r_msg[MSG_SIZE-2:0], iBit};
                r_msg_cnt <= r_msg_cnt + 1'b1;
            end
            if (w_key_take) begin
                r_key     <= {r_key[KEY_SIZE-2:0], iBit};
                r_key_cnt <= r_key_cnt + 1'b1;
            end

            if (w_in_enc && (w_state_next == S_CLEAR))
                r_error <= 1'b1;
            else if (w_msg_take || w_key_take)
                r_error <= 1'b0;

            // Counter restarts on every state change, so each status edge gets a full budget.
            if (w_state_next != r_state)
                r_tmo <= '0;
            else if (w_in_enc)
                r_tmo <= r_tmo + 1'b1;

            if ((r_state == S_ENC_FALL) && (w_state_next == S_SEND)) begin
                r_shreg    <= iCiphertext;
                r_sent_cnt <= '0;
            end else if (w_accept) begin
                r_shreg    <= {r_shreg[MSG_SIZE-2:0], 1'b0};
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end

            if (r_state == S_CLEAR) begin
                r_msg      <= '0;
                r_key      <= '0;
                r_msg_cnt  <= '0;
                r_key_cnt  <= '0;
                r_shreg    <= '0;
                r_sent_cnt <= '0;
            end
        end
    end

    assign oMessage             = r_msg;
    assign oKey                 = r_key;
    assign oMessage_bit_counter = r_msg_cnt;
    assign oKey_bit_counter     = r_key_cnt;
    assign oEngine_ena          = r_eng_ena;
    assign oEngine_rst_n        = r_eng_rst_n;
    assign oSerial_out          = r_shreg[MSG_SIZE-1];
    assign oSerial_valid        = r_valid;
    assign oBusy                = (r_state != S_LOAD);
    assign oDone                = r_done;
    assign oError               = r_error;
endmodule
